// File: rtl/lfsr_prbs_checker.sv
// Self-synchronising PRBS checker for a Fibonacci LFSR stream: seeds a local
// LFSR from the data, locks after a run of matches, then flywheels and counts errors.
module lfsr_prbs_checker #(
  parameter int                   BIT_WIDTH = 8,
  parameter logic [BIT_WIDTH-1:0] TAPS      = 8'hB8,
  parameter int                   LOCK_CNT  = 4,
  parameter int                   LOSS_CNT  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 din_vld,
  input  logic                 din_done,
  input  logic [BIT_WIDTH-1:0] din_data,
  input  logic                 clr_cnt,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [15:0]          err_cnt,
  output logic [31:0]          word_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SYNC  = 2'd1,
    S_CHECK = 2'd2
  } state_t;

  localparam logic [7:0] LOCK_LIM = 8'(LOCK_CNT);
  localparam logic [7:0] LOSS_LIM = 8'(LOSS_CNT);

  state_t               r_state;
  logic [BIT_WIDTH-1:0] r_exp;
  logic [7:0]           r_match_cnt;
  logic [7:0]           r_miss_cnt;

  logic w_check_beat;
  logic w_miss;

  function automatic logic [BIT_WIDTH-1:0] f_nxt(input logic [BIT_WIDTH-1:0] s);
    return {s[BIT_WIDTH-2:0], ^(s & TAPS)};
  endfunction

  assign w_check_beat = enable & din_vld & (r_state == S_CHECK);
  assign w_miss       = (din_data != r_exp);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_exp       <= '0;
      r_match_cnt <= '0;
      r_miss_cnt  <= '0;
      locked      <= 1'b0;
      err_pulse   <= 1'b0;
    end else begin
      // NOTE: all state uses <= so every branch below reads pre-edge values.
      err_pulse <= 1'b0;
      if (!enable) begin
        r_state <= S_IDLE;
        locked  <= 1'b0;
      end else if (din_vld) begin
        unique case (r_state)
          S_IDLE: begin
            if (din_data != '0) begin
              r_exp       <= f_nxt(din_data);
              r_match_cnt <= '0;
              r_state     <= S_SYNC;
            end
          end
          S_SYNC: begin
            if (!w_miss) begin
              r_exp       <= f_nxt(din_data);
              r_match_cnt <= r_match_cnt + 8'd1;
              if (r_match_cnt + 8'd1 == LOCK_LIM) begin
                r_state    <= S_CHECK;
                locked     <= 1'b1;
                r_miss_cnt <= '0;
              end
            end else if (din_data == '0) begin
              r_match_cnt <= '0;
            end else begin
              r_exp       <= f_nxt(din_data);
              r_match_cnt <= '0;
            end
          end
          S_CHECK: begin
            // Flywheel: the local LFSR advances on its own, independent of data.
            r_exp <= f_nxt(r_exp);
            if (w_miss) begin
              err_pulse <= 1'b1;
              if (r_miss_cnt + 8'd1 == LOSS_LIM) begin
                r_state     <= S_SYNC;
                locked      <= 1'b0;
                r_exp       <= f_nxt(din_data);
                r_match_cnt <= '0;
                r_miss_cnt  <= '0;
              end else begin
                r_miss_cnt <= r_miss_cnt + 8'd1;
              end
            end else begin
              r_miss_cnt <= '0;
            end
          end
          default: r_state <= S_IDLE;
        endcase
        if (din_done) begin
          r_state <= S_IDLE;
          locked  <= 1'b0;
        end
      end
    end
  end

  // Saturating counters; a coincident clear beats any increment.
  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      err_cnt  <= '0;
      word_cnt <= '0;
    end else begin
      if (w_check_beat && word_cnt != '1)
        word_cnt <= word_cnt + 32'd1;
      if (w_check_beat && w_miss && err_cnt != '1)
        err_cnt <= err_cnt + 16'd1;
    end
  end

endmodule
